// File: rtl/spi_master_pkg.sv
// Shared definitions for the SPI initiator: frame geometry, R/W encoding and FSM states.
package spi_master_pkg;

   localparam int   SPI_ADDRW      = 7;
   localparam int   SPI_DATAW      = 8;
   localparam int   SPI_FRAME_BITS = SPI_ADDRW + 1 + SPI_DATAW;
   localparam logic SPI_READ       = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_HOLD  = 2'd2,
      ST_DONE  = 2'd3
   } spi_state_e;

endpackage

// File: rtl/spi_master_if.sv
// Host-side handshake and SPI pin bundle for spi_master.
interface spi_master_if #(
   parameter int ADDRW = 7,
   parameter int DATAW = 8
);
   logic             start;
   logic             rw;
   logic [ADDRW-1:0] addr;
   logic [DATAW-1:0] wdata;
   logic             busy;
   logic             done;
   logic [DATAW-1:0] rdata;
   logic             sclk;
   logic             cs;
   logic             mosi;
   logic             miso;

   modport master (
      input  start, rw, addr, wdata, miso,
      output busy, done, rdata, sclk, cs, mosi
   );

   modport slave (
      output start, rw, addr, wdata, miso,
      input  busy, done, rdata, sclk, cs, mosi
   );
endinterface

// File: rtl/spi_master_clkgen.sv
// SPI clock generator: toggles sclk every CLKDIV clk cycles while enabled, idles low otherwise.
module spi_master_clkgen #(
   parameter int CLKDIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   output logic sclk,
   output logic rise_strobe,
   output logic fall_strobe
);
   localparam logic [7:0] RELOAD = 8'(CLKDIV - 1);

   logic [7:0] cnt_q, cnt_d;
   logic       sclk_q, sclk_d;
   logic       tick;

   always_comb begin
      cnt_d  = cnt_q;
      sclk_d = sclk_q;
      tick   = enable && (cnt_q == '0);
      if (!enable) begin
         cnt_d  = RELOAD;
         sclk_d = 1'b0;
      end else if (tick) begin
         cnt_d  = RELOAD;
         sclk_d = !sclk_q;
      end else begin
         cnt_d  = cnt_q - 1'b1;
      end
   end

   // strobes mark the clk edge at which sclk changes, so users act in lockstep
   assign rise_strobe = tick && !sclk_q;
   assign fall_strobe = tick && sclk_q;
   assign sclk        = sclk_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= '0;
         sclk_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         sclk_q <= sclk_d;
      end
   end
endmodule

// File: rtl/spi_master.sv
// SPI mode-0 initiator: one {addr, rw, data} frame per start, read data captured into rdata.
//   state | meaning
//   IDLE  | cs high, waiting for start
//   SHIFT | cs low, 32 sclk half-periods shifting the frame
//   HOLD  | cs low, sclk low for CLKDIV cycles after the last edge
//   DONE  | one cycle, cs high, done pulse, rdata updated on reads
module spi_master
   import spi_master_pkg::*;
#(
   parameter int CLKDIV = 4,
   parameter int ADDRW  = SPI_ADDRW,
   parameter int DATAW  = SPI_DATAW
) (
   input logic          clk,
   input logic          reset,
   spi_master_if.master bus
);
   localparam int             FRAMEW      = ADDRW + 1 + DATAW;
   localparam int             EDGEW       = $clog2(2 * FRAMEW);
   localparam logic [EDGEW-1:0] LAST_EDGE = EDGEW'(2 * FRAMEW - 1);
   localparam logic [7:0]     HOLD_RELOAD = 8'(CLKDIV - 1);

   spi_state_e       state_q, state_d;
   logic [FRAMEW-1:0] tx_q, tx_d;
   logic [DATAW-1:0]  rx_q, rx_d;
   logic [DATAW-1:0]  rdata_q, rdata_d;
   logic              rw_q, rw_d;
   logic [EDGEW-1:0]  edge_q, edge_d;
   logic [7:0]        hold_q, hold_d;
   logic              sclk, rise, fall;

   spi_master_clkgen #(.CLKDIV(CLKDIV)) u_clkgen (
      .clk         (clk),
      .reset       (reset),
      .enable      (state_q == ST_SHIFT),
      .sclk        (sclk),
      .rise_strobe (rise),
      .fall_strobe (fall)
   );

   always_comb begin
      state_d = state_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      rdata_d = rdata_q;
      rw_d    = rw_q;
      edge_d  = edge_q;
      hold_d  = hold_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d = ST_SHIFT;
               rw_d    = bus.rw;
               // reads send zeros in the data phase
               tx_d    = {bus.addr, bus.rw, bus.wdata & {DATAW{bus.rw != SPI_READ}}};
               rx_d    = '0;
               edge_d  = '0;
            end
         end
         ST_SHIFT: begin
            if (rise) begin
               rx_d   = {rx_q[DATAW-2:0], bus.miso};
               edge_d = edge_q + 1'b1;
            end
            if (fall) begin
               if (edge_q == LAST_EDGE) begin
                  state_d = ST_HOLD;
                  tx_d    = '0;
                  edge_d  = '0;
                  hold_d  = HOLD_RELOAD;
               end else begin
                  tx_d   = {tx_q[FRAMEW-2:0], 1'b0};
                  edge_d = edge_q + 1'b1;
               end
            end
         end
         ST_HOLD: begin
            if (hold_q == '0) begin
               state_d = ST_DONE;
               if (rw_q == SPI_READ) rdata_d = rx_q;
            end else begin
               hold_d = hold_q - 1'b1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         tx_q    <= '0;
         rx_q    <= '0;
         rdata_q <= '0;
         rw_q    <= 1'b0;
         edge_q  <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         rdata_q <= rdata_d;
         rw_q    <= rw_d;
         edge_q  <= edge_d;
         hold_q  <= hold_d;
      end
   end

   assign bus.cs    = !((state_q == ST_SHIFT) || (state_q == ST_HOLD));
   assign bus.busy  = (state_q == ST_SHIFT) || (state_q == ST_HOLD);
   assign bus.done  = (state_q == ST_DONE);
   assign bus.rdata = rdata_q;
   assign bus.sclk  = sclk;
   assign bus.mosi  = tx_q[FRAMEW-1];
endmodule
